// File: rtl/img_pkg.sv
// Shared constants and state encoding for the image sequencer and its address generator.
package img_pkg;

    localparam int DEF_TOTAL_BYTES = 784;
    localparam int DEF_NUM_IMG     = 4;
    localparam int RES_W           = 4;
    localparam int DATA_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Counter width able to index n values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_addr_gen.sv
// ROM address generation: per-image base stepped by TOTAL_BYTES, pixel offset
// within the current frame, selected image index and the last-pixel flag.
module img_addr_gen
    import img_pkg::*;
#(
    parameter int TOTAL_BYTES = DEF_TOTAL_BYTES,
    parameter int NUM_IMG     = DEF_NUM_IMG,
    parameter int ADDR_W      = 12,
    parameter int IDX_W       = width_of(DEF_NUM_IMG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_pix,
    input  logic              inc_pix,
    input  logic              advance,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              last_pix,
    output logic [IDX_W-1:0]  img_idx
);

    localparam int CNT_W = width_of(TOTAL_BYTES);
    localparam logic [CNT_W-1:0]  PIX_LAST = CNT_W'(TOTAL_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_IMG - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(TOTAL_BYTES);

    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] base;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (clr_pix) begin
            pix_cnt <= '0;
        end else if (inc_pix) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    // Base follows the image index by accumulation, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_idx <= '0;
            base    <= '0;
        end else if (advance) begin
            if (img_idx == IDX_LAST) begin
                img_idx <= '0;
                base    <= '0;
            end else begin
                img_idx <= img_idx + IDX_W'(1);
                base    <= base + STEP;
            end
        end
    end

    assign rom_addr = base + ADDR_W'(pix_cnt);
    assign last_pix = (pix_cnt == PIX_LAST);

endmodule

// File: rtl/img_seq_ctrl.sv
// Streams stored images pixel by pixel from a synchronous ROM to a CNN at a fixed
// pace, collects the classification, and optionally walks through all images.
module img_seq_ctrl
    import img_pkg::*;
#(
    parameter int  TOTAL_BYTES  = DEF_TOTAL_BYTES,
    parameter int  NUM_IMG      = DEF_NUM_IMG,
    parameter int  CLK_INTERVAL = 12,
    parameter int  TIMEOUT      = 65535,
    parameter int  ADDR_W       = 12,
    localparam int IDX_W        = width_of(NUM_IMG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] pix_dout,
    output logic              pix_vld,
    input  logic              cnn_done,
    input  logic [RES_W-1:0]  cnn_result,
    output logic [RES_W-1:0]  result,
    output logic              result_vld,
    output logic [IDX_W-1:0]  img_idx,
    output logic              busy,
    output logic              err
);

    localparam int INT_W = width_of(CLK_INTERVAL + 1);
    localparam int TO_W  = width_of(TIMEOUT + 1);
    localparam logic [INT_W-1:0] INT_LAST = INT_W'(CLK_INTERVAL);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic [INT_W-1:0] int_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             rd_pend;
    logic             last_pix, inc_pix, clr_pix, advance, capture, timeout, clr_err;

    img_addr_gen #(
        .TOTAL_BYTES (TOTAL_BYTES),
        .NUM_IMG     (NUM_IMG),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clr_pix  (clr_pix),
        .inc_pix  (inc_pix),
        .advance  (advance),
        .rom_addr (rom_addr),
        .last_pix (last_pix),
        .img_idx  (img_idx)
    );

    always_comb begin
        next_state = state;
        rom_en     = 1'b0;
        inc_pix    = 1'b0;
        advance    = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        clr_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_FETCH;
                    clr_err    = 1'b1;
                end
            end
            ST_FETCH: begin
                rom_en = (int_cnt == '0);
                if (int_cnt == INT_LAST) begin
                    if (last_pix) begin
                        next_state = ST_WAIT_RES;
                    end else begin
                        inc_pix = 1'b1;
                    end
                end
            end
            ST_WAIT_RES: begin
                if (cnn_done) begin
                    capture    = 1'b1;
                    advance    = 1'b1;
                    next_state = continuous ? ST_FETCH : ST_DONE;
                end else if (to_cnt == TO_LAST) begin
                    timeout    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        // Abort cancels whatever the state asked for, including a read issued this cycle.
        if (abort) begin
            next_state = ST_IDLE;
            rom_en     = 1'b0;
            inc_pix    = 1'b0;
            advance    = 1'b0;
            capture    = 1'b0;
            timeout    = 1'b0;
            clr_err    = 1'b0;
        end
    end

    // Pixel offset is held at zero everywhere outside an ongoing frame.
    assign clr_pix = (state != ST_FETCH) || (next_state != ST_FETCH);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            int_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH && next_state == ST_FETCH) begin
                int_cnt <= (int_cnt == INT_LAST) ? '0 : int_cnt + INT_W'(1);
            end else begin
                int_cnt <= '0;
            end
            if (state == ST_WAIT_RES && next_state == ST_WAIT_RES) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ROM data arrives the cycle after rom_en; it is registered so pix_vld lands two cycles after.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            pix_vld  <= 1'b0;
            pix_dout <= '0;
        end else begin
            rd_pend <= rom_en;
            pix_vld <= rd_pend && !abort;
            if (rd_pend && !abort) begin
                pix_dout <= rom_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            result_vld <= 1'b0;
            err        <= 1'b0;
        end else begin
            result_vld <= capture;
            if (capture) begin
                result <= cnn_result;
            end
            if (timeout) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_img_seq_ctrl.sv
// Self-checking bench for img_seq_ctrl: randomized ROM contents, result values and
// response delays, checked against pixel timing computed from the frame arithmetic.
module tb_img_seq_ctrl;

    localparam int TB = 64;
    localparam int NI = 4;
    localparam int CI = 12;
    localparam int TO = 100;
    localparam int AW = 12;
    localparam int P  = CI + 1;
    localparam int IW = $clog2(NI);
    localparam int AP = 30;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0, cnn_done = 1'b0;
    logic [3:0]    cnn_result = '0;
    logic          rom_en, pix_vld, result_vld, busy, err;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_dout = '0;
    logic [7:0]    pix_dout;
    logic [3:0]    result;
    logic [IW-1:0] img_idx;

    logic [7:0] rom [TB*NI];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int en_cyc[$], en_addr[$], vld_cyc[$], vld_data[$], rv_cyc[$], rv_val[$];
    int exp_idx = 0;
    int exp_res = 0;

    img_seq_ctrl #(
        .TOTAL_BYTES  (TB),
        .NUM_IMG      (NI),
        .CLK_INTERVAL (CI),
        .TIMEOUT      (TO),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .pix_dout   (pix_dout),
        .pix_vld    (pix_vld),
        .cnn_done   (cnn_done),
        .cnn_result (cnn_result),
        .result     (result),
        .result_vld (result_vld),
        .img_idx    (img_idx),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rom_en && int'(rom_addr) < TB*NI) rom_dout <= rom[int'(rom_addr)];
    end

    // Event log of every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (rom_en) begin en_cyc.push_back(cyc); en_addr.push_back(int'(rom_addr)); end
        if (pix_vld) begin vld_cyc.push_back(cyc); vld_data.push_back(int'(pix_dout)); end
        if (result_vld) begin rv_cyc.push_back(cyc); rv_val.push_back(int'(result)); end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_log();
        en_cyc.delete(); en_addr.delete(); vld_cyc.delete();
        vld_data.delete(); rv_cyc.delete(); rv_val.delete();
    endtask

    task automatic pulse_start(output int t);
        t = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (rom_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_en got %b want 0", rom_en); end
        checks++; if (rom_addr !== '0) begin errors++; $display("[TB] FAIL reset_rom_addr got %0h want 0", rom_addr); end
        checks++; if (pix_dout !== '0) begin errors++; $display("[TB] FAIL reset_pix_dout got %0h want 0", pix_dout); end
        checks++; if (pix_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_vld got %b want 0", pix_vld); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result got %0h want 0", result); end
        checks++; if (result_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_vld got %b want 0", result_vld); end
        checks++; if (img_idx !== '0) begin errors++; $display("[TB] FAIL reset_img_idx got %0d want 0", img_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        step();
        exp_idx = 0;
        exp_res = 0;
    endtask

    task automatic test_frame();
        int t, base, sc, dc, v;
        clear_log();
        base = exp_idx * TB;
        v = (exp_res + 1 + $urandom_range(0, 14)) % 16;
        pulse_start(t);
        sc = t + 1 + $urandom_range(2, TB*P - 20);
        dc = t + 1 + $urandom_range(2, TB*P - 20);
        // Stray start and cnn_done while fetching must leave the frame untouched.
        while (cyc < t + 3 + TB*P) begin
            start = (cyc == sc);
            cnn_done = (cyc == dc);
            cnn_result = 4'(v);
            step();
        end
        start = 1'b0;
        cnn_done = 1'b0;
        checks++;
        if (en_cyc.size() != TB) begin errors++; $display("[TB] FAIL frame_rom_en_count got %0d want %0d", en_cyc.size(), TB); end
        for (int k = 0; k < TB && k < en_cyc.size(); k++) begin
            checks++;
            if (en_cyc[k] != t + 1 + k*P || en_addr[k] != base + k) begin
                errors++;
                $display("[TB] FAIL frame_rom_en[%0d] got cycle %0d addr %0d want cycle %0d addr %0d", k, en_cyc[k], en_addr[k], t + 1 + k*P, base + k);
            end
        end
        checks++;
        if (vld_cyc.size() != TB) begin errors++; $display("[TB] FAIL frame_pix_vld_count got %0d want %0d", vld_cyc.size(), TB); end
        for (int k = 0; k < TB && k < vld_cyc.size(); k++) begin
            checks++;
            if (vld_cyc[k] != t + 3 + k*P || vld_data[k] != int'(rom[base + k])) begin
                errors++;
                $display("[TB] FAIL frame_pix[%0d] got cycle %0d data %0h want cycle %0d data %0h", k, vld_cyc[k], vld_data[k], t + 3 + k*P, rom[base + k]);
            end
        end
        checks++; if (busy !== 1'b1 || rom_en !== 1'b0) begin errors++; $display("[TB] FAIL frame_wait_res got busy %b rom_en %b want 1 0", busy, rom_en); end
        checks++; if (rv_cyc.size() != 0 || result !== 4'(exp_res)) begin errors++; $display("[TB] FAIL frame_stray_done got result %0d pulses %0d want %0d 0", result, rv_cyc.size(), exp_res); end
        cnn_done = 1'b1;
        cnn_result = 4'd7;
        continuous = 1'b0;
        step();
        cnn_done = 1'b0;
        checks++; if (result_vld !== 1'b1 || result !== 4'd7) begin errors++; $display("[TB] FAIL answer_result got vld %b result %0d want 1 7", result_vld, result); end
        checks++; if (img_idx !== IW'((exp_idx + 1) % NI)) begin errors++; $display("[TB] FAIL answer_img_idx got %0d want %0d", img_idx, (exp_idx + 1) % NI); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL answer_done_state got busy %b want 1", busy); end
        step();
        checks++; if (result_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL answer_idle got vld %b busy %b want 0 0", result_vld, busy); end
        exp_idx = (exp_idx + 1) % NI;
        exp_res = 7;
    endtask

    task automatic test_midframe_reset();
        int t;
        pulse_start(t);
        go_to(t + 1 + $urandom_range(P, 10*P));
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || rom_en !== 1'b0 || pix_vld !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl got busy %b rom_en %b pix_vld %b want 0 0 0", busy, rom_en, pix_vld); end
        checks++; if (img_idx !== '0 || result !== '0 || rom_addr !== '0) begin errors++; $display("[TB] FAIL midreset_regs got idx %0d result %0d addr %0d want 0 0 0", img_idx, result, rom_addr); end
        clear_log();
        repeat (2*P) step();
        checks++; if (en_cyc.size() != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_quiet got rom_en %0d busy %b want 0 0", en_cyc.size(), busy); end
        exp_idx = 0;
        exp_res = 0;
    endtask

    task automatic test_continuous();
        int s[NI+1];
        int v[NI];
        int dc;
        clear_log();
        pulse_start(s[0]);
        for (int f = 0; f < NI; f++) begin
            dc = s[f] + 1 + TB*P + $urandom_range(0, 8);
            go_to(dc);
            v[f] = $urandom_range(0, 15);
            cnn_result = 4'(v[f]);
            cnn_done = 1'b1;
            continuous = 1'b1;
            step();
            cnn_done = 1'b0;
            continuous = 1'b0;
            s[f+1] = dc;
        end
        checks++; if (img_idx !== '0 || rom_en !== 1'b1 || rom_addr !== '0) begin errors++; $display("[TB] FAIL cont_wrap got idx %0d rom_en %b addr %0d want 0 1 0", img_idx, rom_en, rom_addr); end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (2*P) step();
        for (int f = 0; f <= NI; f++) begin
            checks++;
            if (f*TB >= en_cyc.size()) begin
                errors++; $display("[TB] FAIL cont_frame%0d_first got no read want cycle %0d", f, s[f] + 1);
            end else if (en_cyc[f*TB] != s[f] + 1 || en_addr[f*TB] != (f % NI) * TB) begin
                errors++; $display("[TB] FAIL cont_frame%0d_first got cycle %0d addr %0d want cycle %0d addr %0d", f, en_cyc[f*TB], en_addr[f*TB], s[f] + 1, (f % NI) * TB);
            end
        end
        checks++; if (en_cyc.size() != NI*TB + 1) begin errors++; $display("[TB] FAIL cont_rom_en_count got %0d want %0d", en_cyc.size(), NI*TB + 1); end
        checks++; if (vld_cyc.size() != NI*TB) begin errors++; $display("[TB] FAIL cont_pix_vld_count got %0d want %0d", vld_cyc.size(), NI*TB); end
        checks++; if (rv_cyc.size() != NI) begin errors++; $display("[TB] FAIL cont_result_count got %0d want %0d", rv_cyc.size(), NI); end
        for (int f = 0; f < NI && f < rv_cyc.size(); f++) begin
            checks++;
            if (rv_cyc[f] != s[f+1] + 1 || rv_val[f] != v[f]) begin
                errors++; $display("[TB] FAIL cont_result%0d got cycle %0d val %0d want cycle %0d val %0d", f, rv_cyc[f], rv_val[f], s[f+1] + 1, v[f]);
            end
        end
        checks++; if (busy !== 1'b0 || img_idx !== '0 || result !== 4'(v[NI-1])) begin errors++; $display("[TB] FAIL cont_abort got busy %b idx %0d result %0d want 0 0 %0d", busy, img_idx, result, v[NI-1]); end
        exp_idx = 0;
        exp_res = v[NI-1];
    endtask

    task automatic test_timeout();
        int t, t2, w, base;
        if (exp_idx == 0) begin
            exp_idx = 0;
        end
        base = exp_idx * TB;
        pulse_start(t);
        w = t + 1 + TB*P;
        go_to(w + TO - 1);
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got busy %b err %b want 1 0", busy, err); end
        step();
        checks++; if (busy !== 1'b0 || err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_fire got busy %b err %b want 0 1", busy, err); end
        checks++; if (img_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL timeout_img_idx got %0d want %0d", img_idx, exp_idx); end
        step();
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky got err %b want 1", err); end
        pulse_start(t2);
        checks++; if (err !== 1'b0 || rom_en !== 1'b1 || rom_addr !== AW'(base)) begin errors++; $display("[TB] FAIL timeout_restart got err %b rom_en %b addr %0d want 0 1 %0d", err, rom_en, rom_addr, base); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int t, t2, a, base;
        base = exp_idx * TB;
        clear_log();
        pulse_start(t);
        a = t + 2 + AP*P;
        go_to(a);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || pix_vld !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_stop got busy %b pix_vld %b rom_en %b want 0 0 0", busy, pix_vld, rom_en); end
        repeat (3*P) step();
        checks++; if (en_cyc.size() != AP + 1) begin errors++; $display("[TB] FAIL abort_rom_en_count got %0d want %0d", en_cyc.size(), AP + 1); end
        checks++; if (vld_cyc.size() != AP) begin errors++; $display("[TB] FAIL abort_pix_vld_count got %0d want %0d", vld_cyc.size(), AP); end
        checks++; if (img_idx !== IW'(exp_idx) || result !== 4'(exp_res)) begin errors++; $display("[TB] FAIL abort_retain got idx %0d result %0d want %0d %0d", img_idx, result, exp_idx, exp_res); end
        clear_log();
        pulse_start(t2);
        go_to(t2 + 3);
        checks++; if (pix_vld !== 1'b1 || pix_dout !== rom[base]) begin errors++; $display("[TB] FAIL abort_restart_pix got vld %b data %0h want 1 %0h", pix_vld, pix_dout, rom[base]); end
        checks++;
        if (en_cyc.size() == 0 || en_cyc[0] != t2 + 1 || en_addr[0] != base) begin
            errors++; $display("[TB] FAIL abort_restart_addr got reads %0d want first at cycle %0d addr %0d", en_cyc.size(), t2 + 1, base);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        clear_log();
        repeat (P) step();
        checks++; if (busy !== 1'b0 || en_cyc.size() != 0) begin errors++; $display("[TB] FAIL abort_beats_start got busy %b reads %0d want 0 0", busy, en_cyc.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got cycle %0d want finish earlier", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        foreach (rom[i]) rom[i] = 8'($urandom);
        step();
        test_reset();
        test_frame();
        test_midframe_reset();
        test_continuous();
        test_timeout();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
